detect_burst_len: RTL

- Inverse of the burst-length-to-last expander: consumes a beat stream tagged with a per-beat last flag and reconstructs the burst-length stream.
- Emits one burst_len entry per burst, encoded as beats-1, which is the same encoding the expander consumes.
- Forwards each beat's payload, with the last flag stripped, to a data output FIFO.
- Sits on the write-side of a memory-mapped port, between the kernel's tagged stream and the address/burst issue logic.

---
 rtl/detect_burst_len_pkg.sv | 12 +
 rtl/detect_burst_len.sv | 60 ++++++
 2 files changed

// File: rtl/detect_burst_len_pkg.sv
// Shared definitions for the burst-length expander/detector pair.
// Both sides must agree on the beats-1 encoding and the maximum burst size.
package detect_burst_len_pkg;

    // A burst_len entry holds (beats in burst) - BURST_LEN_OFFSET.
    localparam int unsigned BURST_LEN_OFFSET = 1;

    function automatic int unsigned max_burst_beats(input int unsigned burst_len_width);
        return 32'd1 << burst_len_width;
    endfunction

endpackage

// File: rtl/detect_burst_len.sv
// Rebuilds a burst-length stream from a last-tagged beat stream and forwards
// payloads; bursts reaching the maximum length are force-split.
module detect_burst_len
    import detect_burst_len_pkg::*;
#(
    parameter int DataWidth     = 64,
    parameter int BurstLenWidth = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DataWidth:0]       data_in_dout,
    input  logic                     data_in_empty_n,
    output logic                     data_in_read,
    output logic [DataWidth-1:0]     data_out_din,
    input  logic                     data_out_full_n,
    output logic                     data_out_write,
    output logic [BurstLenWidth-1:0] burst_len_din,
    input  logic                     burst_len_full_n,
    output logic                     burst_len_write,
    output logic                     split_pulse,
    output logic [31:0]              burst_done_count
);

    localparam logic [BurstLenWidth-1:0] COUNT_MAX =
        BurstLenWidth'(max_burst_beats(BurstLenWidth) - BURST_LEN_OFFSET);

    logic [BurstLenWidth-1:0] count;
    logic                     last_in;
    logic                     at_max;
    logic                     term;
    logic                     fire;

    assign last_in = data_in_dout[DataWidth];
    assign at_max  = (count == COUNT_MAX);
    assign term    = last_in | at_max;

    // A terminating beat also needs room in the burst_len FIFO; no partial writes.
    assign fire = data_in_empty_n & data_out_full_n & (~term | burst_len_full_n);

    assign data_in_read    = fire;
    assign data_out_write  = fire;
    assign data_out_din    = data_in_dout[DataWidth-1:0];
    assign burst_len_write = fire & term;
    assign burst_len_din   = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count            <= '0;
            split_pulse      <= 1'b0;
            burst_done_count <= '0;
        end else begin
            if (fire) begin
                count <= term ? '0 : count + BurstLenWidth'(1);
            end
            split_pulse      <= fire & at_max & ~last_in;
            burst_done_count <= burst_done_count + {31'd0, fire & term};
        end
    end

endmodule
